// File: rtl/tx_uart_arbiter.sv
// Round-robin arbiter that grants one of N_REQ requesters the shared TransmitterUART,
// latches its command/length, sequences start/busy/gap, and muxes its buffer to the transmitter.
module tx_uart_arbiter #(
  parameter int N_REQ     = 4,
  parameter int NUMBER    = 8,
  parameter int GAP       = 16,
  parameter int BUSY_WAIT = 4,
  localparam int AW = (NUMBER > 1) ? $clog2(NUMBER) : 1,
  localparam int PW = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   cmd_in,
  input  logic [8*N_REQ-1:0]   len_in,
  input  logic [8*N_REQ-1:0]   rd_data_in,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic                 error,
  output logic                 start,
  output logic [7:0]           cmd_tx,
  output logic [7:0]           len_tx,
  input  logic                 tx_busy,
  input  logic [AW-1:0]        rd_addr,
  input  logic                 rd_clock,
  output logic [7:0]           rd_data,
  output logic [AW-1:0]        req_rd_addr,
  output logic                 req_rd_clock
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_BUSY,
    S_GAP
  } state_t;

  localparam logic [8:0]  LEN_MAX   = 9'(NUMBER - 1);
  localparam logic [7:0]  GAP_LAST  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
  localparam logic [15:0] WAIT_LAST = (BUSY_WAIT > 0) ? 16'(BUSY_WAIT - 1) : 16'd0;

  state_t         state, state_next;
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  win;
  logic           clamp_q;
  logic [15:0]    wait_cnt;
  logic [7:0]     gap_cnt;

  logic [PW-1:0]  pick_idx;
  logic           pick_found;
  logic [7:0]     len_sel;
  logic           clamp_now;

  // Circular search for the first active request at or after ptr.
  always_comb begin
    int idx;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pick_idx   = '0;
    pick_found = 1'b0;
    idx        = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(idx);
      end
    end
  end

  assign len_sel   = len_in[8*pick_idx +: 8];
  assign clamp_now = {1'b0, len_sel} > LEN_MAX;

  always_comb begin
    state_next = state;
    start      = 1'b0;
    error      = 1'b0;
    done       = '0;
    case (state)
      S_IDLE: begin
        if (|req) state_next = S_START;
      end
      S_START: begin
        start      = 1'b1;
        error      = clamp_q;
        state_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = S_BUSY;
        end else if (wait_cnt == WAIT_LAST) begin
          error      = 1'b1;
          state_next = S_GAP;
        end
      end
      S_BUSY: begin
        if (!tx_busy) begin
          done[win]  = 1'b1;
          state_next = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // A reset cycle aborts the frame silently.
    if (reset) begin
      start = 1'b0;
      error = 1'b0;
      done  = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state    <= S_IDLE;
      ptr      <= '0;
      win      <= '0;
      grant    <= '0;
      cmd_tx   <= 8'h00;
      len_tx   <= 8'h00;
      clamp_q  <= 1'b0;
      wait_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && pick_found) begin
        win     <= pick_idx;
        grant   <= N_REQ'(1) << pick_idx;
        cmd_tx  <= cmd_in[8*pick_idx +: 8];
        len_tx  <= clamp_now ? LEN_MAX[7:0] : len_sel;
        clamp_q <= clamp_now;
      end
      if (state == S_START)          wait_cnt <= '0;
      else if (state == S_WAIT_BUSY) wait_cnt <= wait_cnt + 16'd1;
      if (state != S_GAP && state_next == S_GAP) begin
        grant   <= '0;
        ptr     <= (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
        gap_cnt <= '0;
      end else if (state == S_GAP) begin
        gap_cnt <= gap_cnt + 8'd1;
      end
    end
  end

  assign rd_data      = (grant != '0) ? rd_data_in[8*win +: 8] : 8'h00;
  assign req_rd_addr  = rd_addr;
  assign req_rd_clock = rd_clock;

endmodule

// File: tb/tb_tx_uart_arbiter.sv
// Directed bench for tx_uart_arbiter with defaults N_REQ=4, NUMBER=8, GAP=16, BUSY_WAIT=4.
module tb_tx_uart_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, grant, done;
  logic [31:0] cmd_in, len_in, rd_data_in;
  logic        error, start, tx_busy, rd_clock, req_rd_clock;
  logic [7:0]  cmd_tx, len_tx, rd_data;
  logic [2:0]  rd_addr, req_rd_addr;
  logic [7:0]  mem [4][8];

  int n_checks = 0;
  int n_pass   = 0;

  tx_uart_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .cmd_in(cmd_in), .len_in(len_in),
    .rd_data_in(rd_data_in), .grant(grant), .done(done), .error(error),
    .start(start), .cmd_tx(cmd_tx), .len_tx(len_tx), .tx_busy(tx_busy),
    .rd_addr(rd_addr), .rd_clock(rd_clock), .rd_data(rd_data),
    .req_rd_addr(req_rd_addr), .req_rd_clock(req_rd_clock)
  );

  always #5 clk = ~clk;

  assign rd_data_in = {mem[3][rd_addr], mem[2][rd_addr], mem[1][rd_addr], mem[0][rd_addr]};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for a start pulse; an expired bound is a failed comparison.
  task automatic wait_start(input string name, output int cyc);
    cyc = -1;
    for (int i = 0; i < 100; i++) begin
      if (start === 1'b1) begin
        cyc = i;
        break;
      end
      tick();
    end
    n_checks++;
    if (cyc < 0) $display("FAIL %s_start_timeout: no start within 100 cycles", name);
    else n_pass++;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    req     = '0;
    tx_busy = 1'b0;
    cmd_in  = '0;
    len_in  = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; tx_busy = 1'b0; cmd_in = '0; len_in = '0;
    rd_addr = 3'd2; rd_clock = 1'b0;
    tick(); tick();
    n_checks++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", grant); else n_pass++;
    n_checks++; if (done !== 4'b0000) $display("FAIL reset_done: got %b want 0000", done); else n_pass++;
    n_checks++; if ({error, start} !== 2'b00) $display("FAIL reset_err_start: got %b want 00", {error, start}); else n_pass++;
    n_checks++; if ({cmd_tx, len_tx} !== 16'h0000) $display("FAIL reset_cmd_len: got %h want 0000", {cmd_tx, len_tx}); else n_pass++;
    n_checks++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h want 00", rd_data); else n_pass++;
    req = 4'b1111; cmd_in = 32'hFFFF_FFFF;
    tick();
    n_checks++; if ({start, grant} !== 5'b0) $display("FAIL reset_priority: got start/grant %b want 00000", {start, grant}); else n_pass++;
    n_checks++; if (cmd_tx !== 8'h00) $display("FAIL reset_priority_cmd: got %h want 00", cmd_tx); else n_pass++;
    reset = 1'b0; req = '0; cmd_in = '0;
  endtask

  task automatic test_single();
    int cyc, extra_start, bad_done;
    do_reset();
    req = 4'b0001; cmd_in[7:0] = 8'hA5; len_in[7:0] = 8'd7;
    tick();
    wait_start("single", cyc);
    n_checks++; if (grant !== 4'b0001) $display("FAIL single_grant: got %b want 0001", grant); else n_pass++;
    n_checks++; if ({cmd_tx, len_tx} !== 16'hA507) $display("FAIL single_latch: got %h want a507", {cmd_tx, len_tx}); else n_pass++;
    n_checks++; if (error !== 1'b0) $display("FAIL single_no_clamp_err: got %b want 0", error); else n_pass++;
    cmd_in[7:0] = 8'hFF; len_in[7:0] = 8'd3;
    extra_start = 0; bad_done = 0;
    tick(); tick();
    tx_busy = 1'b1;
    for (int k = 0; k < 499; k++) begin
      tick();
      if (start) extra_start++;
      if (done != 4'b0000 || error) bad_done++;
    end
    tick();
    tx_busy = 1'b0; #1;
    n_checks++; if (extra_start != 0) $display("FAIL single_one_start: got %0d extra starts want 0", extra_start); else n_pass++;
    n_checks++; if (bad_done != 0) $display("FAIL single_quiet_busy: got %0d early done/error cycles want 0", bad_done); else n_pass++;
    n_checks++; if (done !== 4'b0001) $display("FAIL single_done: got %b want 0001", done); else n_pass++;
    n_checks++; if ({cmd_tx, len_tx} !== 16'hA507) $display("FAIL single_hold: got %h want a507", {cmd_tx, len_tx}); else n_pass++;
    tick();
    n_checks++; if ({grant, done} !== 8'h00) $display("FAIL single_gap: got grant/done %b want 00000000", {grant, done}); else n_pass++;
    cyc = -1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (start) begin cyc = k; break; end
    end
    n_checks++; if (cyc != 17) $display("FAIL single_gap_len: got next start after %0d cycles want 17", cyc); else n_pass++;
    n_checks++; if (grant !== 4'b0001) $display("FAIL single_regrant: got %b want 0001", grant); else n_pass++;
    req = '0;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    int cyc;
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    do_reset();
    req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_start("rr", cyc);
      n_checks++; if (grant !== exp_g[f]) $display("FAIL rr_frame%0d: got %b want %b", f, grant, exp_g[f]); else n_pass++;
      if (f == 4) req = 4'b1001;
      tick();
    end
    wait_start("rr_skip", cyc);
    n_checks++; if (grant !== 4'b1000) $display("FAIL rr_skip: got %b want 1000", grant); else n_pass++;
    req = '0;
  endtask

  task automatic test_timeout();
    int cyc, n_start;
    do_reset();
    req = 4'b0001;
    tick();
    wait_start("timeout", cyc);
    req = '0;
    tick(); tick(); tick();
    n_checks++; if (error !== 1'b0) $display("FAIL timeout_early: got error %b want 0", error); else n_pass++;
    tick();
    n_checks++; if (error !== 1'b1) $display("FAIL timeout_error: got %b want 1", error); else n_pass++;
    n_checks++; if (done !== 4'b0000) $display("FAIL timeout_no_done: got %b want 0000", done); else n_pass++;
    tick();
    n_checks++; if ({error, grant} !== 5'b0) $display("FAIL timeout_gap: got error/grant %b want 00000", {error, grant}); else n_pass++;
    n_start = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (start || done != 4'b0000) n_start++;
    end
    n_checks++; if (n_start != 0) $display("FAIL timeout_idle_quiet: got %0d active cycles want 0", n_start); else n_pass++;
    req = 4'b0010;
    tick();
    n_checks++; if ({start, grant} !== 5'b10010) $display("FAIL timeout_back_idle: got start/grant %b want 10010", {start, grant}); else n_pass++;
    req = '0;
  endtask

  task automatic test_clamp();
    do_reset();
    req = 4'b0100; cmd_in[23:16] = 8'h5A; len_in[23:16] = 8'd20;
    tick();
    n_checks++; if (start !== 1'b1) $display("FAIL clamp_start: got %b want 1", start); else n_pass++;
    n_checks++; if (len_tx !== 8'd7) $display("FAIL clamp_len: got %0d want 7", len_tx); else n_pass++;
    n_checks++; if (error !== 1'b1) $display("FAIL clamp_error: got %b want 1", error); else n_pass++;
    n_checks++; if (cmd_tx !== 8'h5A) $display("FAIL clamp_cmd: got %h want 5a", cmd_tx); else n_pass++;
    req = '0;
    tick();
    n_checks++; if (error !== 1'b0) $display("FAIL clamp_err_width: got %b want 0", error); else n_pass++;
  endtask

  task automatic test_data_mux();
    do_reset();
    rd_addr = 3'd3; #1;
    n_checks++; if (rd_data !== 8'h00) $display("FAIL mux_idle: got %h want 00", rd_data); else n_pass++;
    req = 4'b0010;
    tick();
    n_checks++; if (rd_data !== 8'h3C) $display("FAIL mux_addr3: got %h want 3c", rd_data); else n_pass++;
    rd_addr = 3'd5; rd_clock = 1'b1; #1;
    n_checks++; if (rd_data !== 8'h15) $display("FAIL mux_addr5: got %h want 15", rd_data); else n_pass++;
    n_checks++; if ({req_rd_addr, req_rd_clock} !== 4'b1011) $display("FAIL mux_fanout: got %b want 1011", {req_rd_addr, req_rd_clock}); else n_pass++;
    rd_clock = 1'b0; #1;
    n_checks++; if (req_rd_clock !== 1'b0) $display("FAIL mux_clock_low: got %b want 0", req_rd_clock); else n_pass++;
    req = '0;
  endtask

  task automatic test_reset_mid_busy();
    int cyc;
    do_reset();
    req = 4'b0010;
    tick();
    wait_start("rmb_pre", cyc);
    req = '0;
    for (int k = 0; k < 40 && grant !== 4'b0000; k++) tick();
    for (int k = 0; k < 17; k++) tick();
    req = 4'b0100;
    tick();
    n_checks++; if ({start, grant} !== 5'b10100) $display("FAIL rmb_second: got start/grant %b want 10100", {start, grant}); else n_pass++;
    req = '0;
    tick(); tick();
    tx_busy = 1'b1;
    tick(); tick();
    reset = 1'b1; tx_busy = 1'b0; #1;
    n_checks++; if ({done, error} !== 5'b0) $display("FAIL rmb_reset_cycle: got done/error %b want 00000", {done, error}); else n_pass++;
    tick();
    n_checks++; if ({grant, start, done, error} !== 10'b0) $display("FAIL rmb_after: got grant/start/done/error %b want 0", {grant, start, done, error}); else n_pass++;
    reset = 1'b0; req = 4'b1111;
    tick();
    n_checks++; if ({start, grant} !== 5'b10001) $display("FAIL rmb_ptr_zero: got start/grant %b want 10001", {start, grant}); else n_pass++;
    req = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int r = 0; r < 4; r++)
      for (int a = 0; a < 8; a++)
        mem[r][a] = 8'((r << 4) | a);
    mem[1][3] = 8'h3C;
    rd_addr = '0; rd_clock = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_clamp();
    test_data_mux();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_uart_arbiter.md
TX_UART_ARBITER -- requirements
Module: tx_uart_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4: number of requesters, 2..8.
REQ-002 The block SHALL have parameter NUMBER, default 8: transmitter buffer depth in bytes, 1..256.
REQ-003 The block SHALL have parameter GAP, default 16: idle clock cycles between frames, 0..255.
REQ-004 The block SHALL have parameter BUSY_WAIT, default 4: cycles allowed after start for tx_busy to rise.
REQ-005 The block SHALL have these ports, listed as name, direction, width, meaning:
- clk  in  1  single clock
- reset  in  1  synchronous active-high reset
- req  in  N_REQ  per-requester frame request, level
- cmd_in  in  8*N_REQ  per-requester command byte
- len_in  in  8*N_REQ  per-requester payload length
- rd_data_in  in  8*N_REQ  per-requester buffer read data
- grant  out  N_REQ  one-hot owner of the transmitter
- done  out  N_REQ  one-cycle frame-complete pulse
- error  out  1  one-cycle pulse on busy timeout or length clamp
- start  out  1  one-cycle start to TransmitterUART
- cmd_tx  out  8  latched command
- len_tx  out  8  latched, clamped length
- tx_busy  in  1  transmitter busy
- rd_addr  in  $clog2(NUMBER)  transmitter buffer address
- rd_clock  in  1  transmitter buffer read strobe
- rd_data  out  8  muxed buffer data to transmitter
- req_rd_addr  out  $clog2(NUMBER)  rd_addr fanned out to all requesters
- req_rd_clock  out  1  rd_clock fanned out to all requesters

Function
REQ-006 The FSM SHALL have exactly the states IDLE, START, WAIT_BUSY, BUSY and GAP.
REQ-007 In IDLE with any req bit high, the block SHALL pick the winner: the first set req index at or after pointer ptr, searching circularly.
REQ-008 In that same IDLE cycle, the block SHALL latch cmd_in[winner] into cmd_tx, latch len_in[winner] (clamped) into len_tx, set grant to one-hot winner, and go to START.
REQ-009 If len_in[winner] > NUMBER-1, the block SHALL load len_tx with NUMBER-1 and pulse error in the START cycle.
REQ-010 In START, the block SHALL assert start for exactly one cycle and then go to WAIT_BUSY; start SHALL never be high in any other state.
REQ-011 In WAIT_BUSY, the block SHALL go to BUSY when tx_busy=1.
REQ-012 If WAIT_BUSY has lasted BUSY_WAIT cycles without tx_busy, the block SHALL pulse error, pulse no done bit, and go to GAP.
REQ-013 In BUSY, on the first cycle with tx_busy=0, the block SHALL pulse done[winner] for one cycle and go to GAP.
REQ-014 On entry to GAP, the block SHALL clear grant to 0 and set ptr to (winner+1) mod N_REQ.
REQ-015 GAP SHALL last GAP cycles before returning to IDLE; with GAP=0 it SHALL last one cycle.
REQ-016 Frame start-to-start latency SHALL be 1 (IDLE) + 1 (START) + busy wait + busy time + GAP cycles.
REQ-017 rd_data SHALL be the combinational value rd_data_in[winner] while grant≠0, and 0 otherwise.
REQ-018 req_rd_addr and req_rd_clock SHALL be combinational pass-throughs of rd_addr and rd_clock.
REQ-019 cmd_in and len_in changes after the latch cycle SHALL NOT affect cmd_tx or len_tx.
REQ-020 A req deasserted after grant SHALL NOT abort the frame; the frame SHALL run to done.
REQ-021 A requester held high continuously SHALL be granted again only after every other active requester has been served once.
REQ-022 tx_busy transitions outside WAIT_BUSY and BUSY SHALL be ignored.

Reset
REQ-023 When reset=1 at a clk edge, the block SHALL enter IDLE with ptr=0, grant=0, done=0, error=0, start=0, cmd_tx=0, len_tx=0, and all counters cleared.
REQ-024 Reset asserted mid-frame SHALL abort the frame, with no done pulse and no error pulse.
REQ-025 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-026 Single request: req=0001, cmd_in[0]=8'hA5, len_in[0]=7; tx_busy high 2 cycles after start, for 500 cycles -> grant=0001, exactly one start pulse with cmd_tx=A5 and len_tx=7, done[0] pulse on the cycle after tx_busy falls, grant=0 in GAP, next grant no earlier than 16 cycles later.
REQ-027 Round robin: req=1111 held high, 4 frames -> grants in order 0001, 0010, 0100, 1000, then 0001 again.
REQ-028 Timeout: tx_busy tied 0 -> error pulse 4 cycles after start, no done pulse, block returns to IDLE after GAP.
REQ-029 Clamp: len_in[2]=8'd20 with NUMBER=8 -> len_tx=7 and an error pulse in the START cycle.
REQ-030 Data mux: requester 1 granted, rd_addr=3, rd_data_in[1] at address 3 = 8'h3C -> rd_data=3C while rd_data_in[0], [2] and [3] differ.
REQ-031 Reset mid-BUSY -> next cycle grant=0, start=0, no done pulse, and the next arbitration starts from requester 0.
